// File: rtl/mem_writer_if.sv
// Bus between the top-level controller / conv engine and mem_writer:
// start/base/result snapshot inputs, memory write port and done pulse.
interface mem_writer_if #(
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned RES_SIZE    = 16
);
  logic                                       start;
  logic [7:0]                                 w_base;
  logic [NUM_FILTERS-1:0][RES_SIZE-1:0][15:0] res_data;
  logic                                       mem_busy;
  logic [7:0]                                 mem_adr;
  logic [7:0]                                 mem_wr_data;
  logic                                       mem_wr_en;
  logic                                       done;

  // Controller / memory side
  modport master (
    output start, w_base, res_data, mem_busy,
    input  mem_adr, mem_wr_data, mem_wr_en, done
  );

  // mem_writer side
  modport slave (
    input  start, w_base, res_data, mem_busy,
    output mem_adr, mem_wr_data, mem_wr_en, done
  );
endinterface

// File: rtl/mem_writer.sv
// mem_writer: snapshots NUM_FILTERS x RES_SIZE signed 16-bit results on start
// and streams them one byte per cycle into data memory from w_base.
// Optional macro MEM_WRITER_CLIP_EN: saturate each value to 0..255 instead of
// truncating to the low byte.
module mem_writer #(
  parameter int unsigned NUM_FILTERS   = 4,
  parameter int unsigned RES_SIZE      = 16,
  parameter int unsigned FILTER_STRIDE = 16
) (
  input  logic        clk,
  input  logic        rst,
  mem_writer_if.slave bus
);

  localparam int unsigned F_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned I_W = (RES_SIZE > 1) ? $clog2(RES_SIZE) : 1;
  localparam logic [F_W-1:0] F_LAST = F_W'(NUM_FILTERS - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(RES_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  typedef logic [NUM_FILTERS-1:0][RES_SIZE-1:0][15:0] snap_t;

  state_t         state_q, state_d;
  logic [F_W-1:0] f_q, f_d;
  logic [I_W-1:0] i_q, i_d;
  logic [7:0]     base_q, base_d;
  snap_t          snap_q, snap_d;
  logic [7:0]     adr_q, adr_d;
  logic [7:0]     data_q, data_d;
  logic           wr_en_q, wr_en_d;
  logic           done_q, done_d;
`ifdef MEM_WRITER_CLIP_EN
  logic signed [15:0] sel;
`endif

  // State, counters, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      i_q     <= '0;
      base_q  <= '0;
      snap_q  <= '0;
      adr_q   <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      i_q     <= i_d;
      base_q  <= base_d;
      snap_q  <= snap_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

  // Next state/counters, then next output values derived from them so the
  // outputs are registered yet reflect the write presented in the next cycle
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    i_d     = i_q;
    base_d  = base_q;
    snap_d  = snap_q;
    adr_d   = '0;
    data_d  = '0;
`ifdef MEM_WRITER_CLIP_EN
    sel     = '0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_d  = bus.res_data;
          base_d  = bus.w_base;
          f_d     = '0;
          i_d     = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!bus.mem_busy) begin
          if (i_q == I_LAST) begin
            i_d = '0;
            if (f_q == F_LAST) begin
              f_d     = '0;
              state_d = DONE;
            end else begin
              f_d = f_q + F_W'(1);
            end
          end else begin
            i_d = i_q + I_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == DONE);

    if (state_d == WRITE) begin
      adr_d = base_d + 8'(32'(f_d) * FILTER_STRIDE) + 8'(i_d);
`ifdef MEM_WRITER_CLIP_EN
      sel = signed'(snap_d[f_d][i_d]);
      if (sel < 16'sd0)
        data_d = 8'h00;
      else if (sel > 16'sd255)
        data_d = 8'hFF;
      else
        data_d = sel[7:0];
`else
      data_d = snap_d[f_d][i_d][7:0];
`endif
    end
  end

  assign bus.mem_adr     = adr_q;
  assign bus.mem_wr_data = data_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: table of full-transfer scenarios (base, data offset,
// stall placement, start/data disturbance) plus reset-mid-write and
// byte-conversion sequences.
module tb_mem_writer;

  localparam int unsigned NF = 4;
  localparam int unsigned RS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_writer_if #(.NUM_FILTERS(NF), .RES_SIZE(RS)) bus ();

  mem_writer #(.NUM_FILTERS(NF), .RES_SIZE(RS), .FILTER_STRIDE(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [15:0] pat     [NF][RS];
  logic [7:0]  exp_dat [NF][RS];

  typedef struct {
    logic [7:0] base;
    int         off;
    int         stall_at;
    int         stall_len;
    bit         disturb;
    int         exp_done;
    logic [7:0] exp_first;
    logic [7:0] exp_last;
  } run_vec_t;

  typedef struct {
    logic [15:0] val;
    logic [7:0]  trunc;
    logic [7:0]  clip;
  } conv_vec_t;

  run_vec_t  runs  [6];
  conv_vec_t convs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Results f*16+i+off (all below 256, so the written byte equals the value)
  task automatic set_pattern(input int off);
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < RS; i++) begin
        pat[f][i]     = 16'(f * 16 + i + off);
        exp_dat[f][i] = 8'(f * 16 + i + off);
      end
  endtask

  task automatic drive_start(input logic [7:0] base);
    @(negedge clk);
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < RS; i++)
        bus.res_data[f][i] = pat[f][i];
    bus.w_base   = base;
    bus.start    = 1'b1;
    bus.mem_busy = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One full transfer; k counts cycles after the start edge (k=1 first write)
  task automatic run_one(input run_vec_t v, input string tag);
    int nw, ndone, stalls, done_k;
    logic [7:0] first_adr, last_adr;
    nw = 0; ndone = 0; stalls = 0; done_k = -1;
    first_adr = 8'h00; last_adr = 8'h00;
    drive_start(v.base);
    for (int k = 1; k <= v.exp_done + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (v.disturb && k == 10) begin
        for (int f = 0; f < NF; f++)
          for (int i = 0; i < RS; i++)
            bus.res_data[f][i] = 16'h00AA;
        bus.w_base = 8'h00;
        bus.start  = 1'b1;
      end
      if (v.disturb && k == 11) bus.start = 1'b0;
      if (k == 1) chk({tag, " first_wr_en"}, 32'(bus.mem_wr_en), 32'd1);
      if (bus.mem_wr_en) begin
        if (nw >= 64) begin
          chk({tag, " extra_write"}, 32'(nw), 32'd63);
          bus.mem_busy = 1'b0;
        end else begin
          chk({tag, " adr"}, 32'(bus.mem_adr), 32'(8'(v.base + 8'(nw))));
          chk({tag, " data"}, 32'(bus.mem_wr_data), 32'(exp_dat[nw / 16][nw % 16]));
          if (nw == 0) first_adr = bus.mem_adr;
          last_adr = bus.mem_adr;
          if (nw == v.stall_at && stalls < v.stall_len) begin
            bus.mem_busy = 1'b1;
            stalls++;
          end else begin
            bus.mem_busy = 1'b0;
            nw++;
          end
        end
      end else begin
        bus.mem_busy = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
    end
    bus.mem_busy = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_k), 32'(v.exp_done));
    chk({tag, " done_count"}, 32'(ndone), 32'd1);
    chk({tag, " writes"}, 32'(nw), 32'd64);
    chk({tag, " first_adr"}, 32'(first_adr), 32'(v.exp_first));
    chk({tag, " last_adr"}, 32'(last_adr), 32'(v.exp_last));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
    run_vec_t cv;

    //        base   off    stall_at len disturb done first  last
    runs[0] = '{8'h40, 0,     -1,     0, 1'b0,   65, 8'h40, 8'h7F};
    runs[1] = '{8'hF8, 16,    -1,     0, 1'b0,   65, 8'hF8, 8'h37};
    runs[2] = '{8'h40, 0,      5,     3, 1'b0,   68, 8'h40, 8'h7F};
    runs[3] = '{8'h00, 32,     0,     1, 1'b0,   66, 8'h00, 8'h3F};
    runs[4] = '{8'hC0, 5,     63,     2, 1'b0,   67, 8'hC0, 8'hFF};
    runs[5] = '{8'h10, 48,    -1,     0, 1'b1,   65, 8'h10, 8'h4F};

    //          value     trunc  clip
    convs[0] = '{16'hFFFB, 8'hFB, 8'h00};
    convs[1] = '{16'h012C, 8'h2C, 8'hFF};
    convs[2] = '{16'h0123, 8'h23, 8'hFF};
    convs[3] = '{16'h8000, 8'h00, 8'h00};
    convs[4] = '{16'h00FF, 8'hFF, 8'hFF};
    convs[5] = '{16'h7FFF, 8'hFF, 8'hFF};
    convs[6] = '{16'h0080, 8'h80, 8'h80};

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.w_base   = 8'h00;
    bus.mem_busy = 1'b0;
    bus.res_data = '0;
    repeat (2) @(negedge clk);
    chk("reset wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset adr", 32'(bus.mem_adr), 32'd0);
    chk("reset data", 32'(bus.mem_wr_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      set_pattern(runs[r].off);
      run_one(runs[r], $sformatf("run%0d", r));
      repeat (2) @(negedge clk);
    end

    // Reset after ten accepted writes, then a full transfer from index 0
    set_pattern(0);
    drive_start(8'h20);
    nw = 0;
    for (int k = 0; k < 40 && nw < 10; k++) begin
      if (bus.mem_wr_en) nw++;
      @(negedge clk);
    end
    chk("midrst writes_before", 32'(nw), 32'd10);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("midrst done", 32'(bus.done), 32'd0);
    chk("midrst adr", 32'(bus.mem_adr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst idle wr_en", 32'(bus.mem_wr_en), 32'd0);
      chk("postrst idle done", 32'(bus.done), 32'd0);
    end
    run_one(runs[0], "after_rst");
    repeat (2) @(negedge clk);

    // Byte conversion of out-of-range and signed values
    set_pattern(0);
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < RS; i++) begin
        pat[f][i]     = 16'h0000;
        exp_dat[f][i] = 8'h00;
      end
    for (int c = 0; c < 7; c++) begin
      pat[0][c] = convs[c].val;
`ifdef MEM_WRITER_CLIP_EN
      exp_dat[0][c] = convs[c].clip;
`else
      exp_dat[0][c] = convs[c].trunc;
`endif
    end
    cv = '{8'h80, 0, -1, 0, 1'b0, 65, 8'h80, 8'hBF};
    run_one(cv, "conv");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
Name: mem_writer

Overview:
- Write-back counterpart of the image/filter memory loader.
- Accepts NUM_FILTERS result vectors from the convolution datapath and snapshots them on start.
- Streams them one byte per cycle into the 256-byte data memory through a single write port, starting at base address w_base.
- Signals done when finished. Sits between the conv engine outputs and data memory, driven by the top-level controller.

Parameters:
- NUM_FILTERS, 4, number of result vectors (one per filter)
- RES_SIZE, 16, results per filter
- FILTER_STRIDE, 16, memory address distance between consecutive filters' result blocks

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-low reset; sampled on the rising edge of clk
- start  input  1  begin write-back; honoured only in IDLE
- w_base  input  8  destination base address, sampled with start
- res_data  input  16 x [NUM_FILTERS][RES_SIZE]  signed results, sampled with start
- mem_busy  input  1  memory stall; when 1 the current write is not accepted
- mem_adr  output  8  write address
- mem_wr_data  output  8  write data
- mem_wr_en  output  1  write strobe
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst=0 at a clock edge):
  - state -> IDLE; all outputs 0; filter/index counters 0; snapshot buffer cleared to 0.
  - Applies in every state, including mid-WRITE: mem_wr_en is 0 from the next cycle and no further writes are issued.
- States: IDLE, WRITE, DONE.
- IDLE:
  - mem_wr_en=0, done=0.
  - On an edge with start=1: res_data is copied into the internal buffer, w_base is latched, counters f=0 and i=0, state -> WRITE.
  - Inputs may change freely after that edge.
- WRITE:
  - mem_wr_en=1.
  - mem_adr = (w_base + f*FILTER_STRIDE + i) mod 256; 8-bit wrap, no error.
  - mem_wr_data = byte conversion of buf[f][i].
  - A write is accepted on an edge where mem_wr_en=1 and mem_busy=0.
  - On acceptance: i increments; when i=RES_SIZE-1, i -> 0 and f increments.
  - After accepting f=NUM_FILTERS-1, i=RES_SIZE-1: state -> DONE.
  - mem_busy=1: address, data and strobe hold unchanged; counters frozen.
- DONE: done=1 for exactly one cycle, mem_wr_en=0, then state -> IDLE.
- start outside IDLE (WRITE or DONE) is ignored; start in the cycle after DONE begins a new transfer.
- Latency:
  - First mem_wr_en=1 appears in the cycle after the start edge.
  - With no stalls, done is high NUM_FILTERS*RES_SIZE+1 cycles after the start edge (65 at defaults).
  - Each stalled cycle adds exactly 1.
- Byte conversion (default): mem_wr_data = res_data[7:0], i.e. truncation.
- Outputs are driven from registered state, counters and buffer; mem_busy does not combinationally affect mem_wr_en.
- Overlapping address blocks (FILTER_STRIDE < RES_SIZE) are permitted; later writes overwrite earlier ones.

Optional Feature:
- Macro: MEM_WRITER_CLIP_EN.
- Defined: byte conversion saturates the signed 16-bit value to 0..255:
  - value < 0 -> 0
  - value > 255 -> 255
  - otherwise the low byte
- Undefined: plain truncation to the low 8 bits; no clip logic is synthesized.

Test Plan:
- Basic run: rst=0 for 2 cycles then 1; w_base=0x40; res_data[f][i]=f*16+i; start pulse, mem_busy=0 -> 64 writes at 0x40..0x7F with data 0x00..0x3F in order; done pulses once, 65 cycles after the start edge.
- Wrap: w_base=0xF8 -> first writes go to 0xF8..0xFF, then 0x00...; last write at 0x37.
- Stall: mem_busy=1 for 3 cycles at write #5 -> mem_adr/mem_wr_data/mem_wr_en held for those cycles; write #5 accepted once; done delayed to 68 cycles.
- Snapshot and ignore: change res_data and pulse start during WRITE -> written data equals the values captured at the first start; no restart; exactly one done.
- Reset mid-operation: rst=0 after write #10 -> mem_wr_en=0 next cycle, no done; a subsequent start performs a full 64-write transfer from index 0.
- Conversion: res_data values -5, 300 and 0x0123 -> written bytes 0xFB, 0x2C, 0x23 without MEM_WRITER_CLIP_EN; 0x00, 0xFF, 0xFF with it defined.
